// File: rtl/pbil_sampler_population.sv
`default_nettype none
// ============================================================================
// Module      : pbil_sampler_population
// Description : Probability-vector (PBIL / compact-GA) population engine.
//               Holds WIDTH probabilities of RESOLUTION bits each. Each
//               generation emits SAMPLES individuals over a valid/ready
//               stream, waits for winner/loser feedback, then moves every
//               probability one saturating step (mode 0 = PBIL toward the
//               winner, mode 1 = cGA only where winner and loser differ).
// Ports       : clk, rst (async, active-low)
//               start                 - begin a generation (IDLE only)
//               mode, tax             - update rule and step size
//               random                - per-bit uniform randoms, slice i at [R*i+:R]
//               ind_valid/ind_ready/individual - sampled individual stream
//               fb_valid/fb_ready/winner/loser - tournament feedback
//               busy, converged, generation    - status
// Revision    : 1.0 - initial release
// ============================================================================
module pbil_sampler_population #(
    parameter int WIDTH      = 32,
    parameter int RESOLUTION = 8,
    parameter int TAX_WIDTH  = 4,
    parameter int SAMPLES    = 2,
    parameter int GEN_WIDTH  = 16,
    parameter logic [RESOLUTION*WIDTH-1:0] INITIAL =
        {WIDTH{{1'b1, {(RESOLUTION-1){1'b0}}}}}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          mode,
    input  logic [TAX_WIDTH-1:0]          tax,
    input  logic [RESOLUTION*WIDTH-1:0]   random,
    output logic                          ind_valid,
    input  logic                          ind_ready,
    output logic [WIDTH-1:0]              individual,
    input  logic                          fb_valid,
    output logic                          fb_ready,
    input  logic [WIDTH-1:0]              winner,
    input  logic [WIDTH-1:0]              loser,
    output logic                          busy,
    output logic                          converged,
    output logic [GEN_WIDTH-1:0]          generation
);

    localparam int CNT_W = (SAMPLES < 2) ? 1 : $clog2(SAMPLES);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(SAMPLES - 1);

    // A vector is converged when every entry sits at either rail.
    function automatic logic f_converged(input logic [RESOLUTION*WIDTH-1:0] v);
        logic c;
        c = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if ((v[RESOLUTION*i +: RESOLUTION] != '0) &&
                (v[RESOLUTION*i +: RESOLUTION] != '1)) begin
                c = 1'b0;
            end
        end
        return c;
    endfunction

    localparam logic c_init_conv = f_converged(INITIAL);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
        S_WAIT   = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;
    logic [RESOLUTION*WIDTH-1:0]   r_prob;
    logic [RESOLUTION*WIDTH-1:0]   w_prob_next;
    logic [WIDTH-1:0]              r_individual;
    logic [WIDTH-1:0]              w_sample;
    logic [WIDTH-1:0]              r_winner;
    logic [WIDTH-1:0]              r_loser;
    logic                          r_mode;
    logic [CNT_W-1:0]              r_count;
    logic                          r_converged;
    logic [GEN_WIDTH-1:0]          r_generation;
    logic [RESOLUTION-1:0]         w_tax;

    assign w_tax = RESOLUTION'(tax);

    // Per-bit sampling and saturating update, all bits in parallel.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [RESOLUTION-1:0] w_p;
        logic [RESOLUTION:0]   w_sum;
        logic [RESOLUTION:0]   w_diff;
        logic                  w_upd;
        logic [RESOLUTION-1:0] w_moved;

        assign w_p         = r_prob[RESOLUTION*i +: RESOLUTION];
        assign w_sample[i] = random[RESOLUTION*i +: RESOLUTION] < w_p;
        assign w_sum       = {1'b0, w_p} + {1'b0, w_tax};
        assign w_diff      = {1'b0, w_p} - {1'b0, w_tax};
        assign w_upd       = r_mode ? (r_winner[i] ^ r_loser[i]) : 1'b1;
        // Carry pins the sum at full scale; borrow pins the difference at zero.
        assign w_moved     = r_winner[i]
                           ? (w_sum[RESOLUTION]  ? '1 : w_sum[RESOLUTION-1:0])
                           : (w_diff[RESOLUTION] ? '0 : w_diff[RESOLUTION-1:0]);
        assign w_prob_next[RESOLUTION*i +: RESOLUTION] = w_upd ? w_moved : w_p;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ind_valid    = 1'b0;
        fb_ready     = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                ind_valid = 1'b1;
                if (ind_ready && (r_count == c_last)) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                fb_ready = 1'b1;
                if (fb_valid) w_state_next = S_UPDATE;
            end
            S_UPDATE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prob       <= INITIAL;
            r_individual <= '0;
            r_winner     <= '0;
            r_loser      <= '0;
            r_mode       <= 1'b0;
            r_count      <= '0;
            r_converged  <= c_init_conv;
            r_generation <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_individual <= w_sample;
                end
                S_SAMPLE: begin
                    if (ind_ready) begin
                        if (r_count == c_last) begin
                            r_count <= '0;
                        end else begin
                            // Next individual drawn from the randoms present at this handshake.
                            r_count      <= r_count + 1'b1;
                            r_individual <= w_sample;
                        end
                    end
                end
                S_WAIT: begin
                    if (fb_valid) begin
                        r_winner <= winner;
                        r_loser  <= loser;
                        r_mode   <= mode;
                    end
                end
                S_UPDATE: begin
                    r_prob      <= w_prob_next;
                    r_converged <= f_converged(w_prob_next);
                    if (r_generation != '1) r_generation <= r_generation + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign individual = r_individual;
    assign converged  = r_converged;
    assign generation = r_generation;

endmodule
`default_nettype wire

// File: tb/tb_pbil_sampler_population.sv
`default_nettype none
// ============================================================================
// Module      : tb_pbil_sampler_population
// Description : Directed self-checking bench for pbil_sampler_population
//               (WIDTH=4, RESOLUTION=8, SAMPLES=2, INITIAL all 128).
//               Probabilities are probed through sampling: random=p-1 must
//               yield 1 and random=p must yield 0 for each entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pbil_sampler_population;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [4:0]  tax = '0;
    logic [31:0] random = '0;
    logic        ind_valid;
    logic        ind_ready = 1'b0;
    logic [3:0]  individual;
    logic        fb_valid = 1'b0;
    logic        fb_ready;
    logic [3:0]  winner = '0;
    logic [3:0]  loser = '0;
    logic        busy;
    logic        converged;
    logic [15:0] generation;

    int n_tests = 0;
    int n_fail  = 0;

    pbil_sampler_population #(
        .WIDTH      (4),
        .RESOLUTION (8),
        .TAX_WIDTH  (5),
        .SAMPLES    (2),
        .GEN_WIDTH  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .tax        (tax),
        .random     (random),
        .ind_valid  (ind_valid),
        .ind_ready  (ind_ready),
        .individual (individual),
        .fb_valid   (fb_valid),
        .fb_ready   (fb_ready),
        .winner     (winner),
        .loser      (loser),
        .busy       (busy),
        .converged  (converged),
        .generation (generation)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [7:0] b3, input logic [7:0] b2,
                                       input logic [7:0] b1, input logic [7:0] b0);
        return {b3, b2, b1, b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Start a generation and take both individuals back to back; ends in WAIT at a negedge.
    task automatic gen_samples(input string tag, input logic [31:0] ra, input logic [31:0] rb,
                               input logic [3:0] exp_a, input logic [3:0] exp_b);
        @(negedge clk);
        start = 1'b1; ind_ready = 1'b1; random = ra;
        @(negedge clk);
        start = 1'b0;
        check({tag, " valid0"}, 32'(ind_valid), 32'd1);
        check({tag, " ind0"}, 32'(individual), 32'(exp_a));
        random = rb;
        @(negedge clk);
        check({tag, " ind1"}, 32'(individual), 32'(exp_b));
        @(negedge clk);
        check({tag, " wait_valid"}, 32'(ind_valid), 32'd0);
        check({tag, " fb_ready"}, 32'(fb_ready), 32'd1);
    endtask

    // Deliver feedback from WAIT; ends back in IDLE at a negedge.
    task automatic feedback(input string tag, input logic m, input logic [3:0] w,
                            input logic [3:0] l, input logic [4:0] t,
                            input int exp_gen, input logic exp_conv);
        fb_valid = 1'b1; mode = m; winner = w; loser = l; tax = t;
        @(negedge clk);
        fb_valid = 1'b0;
        check({tag, " upd_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " gen"}, 32'(generation), 32'(exp_gen));
        check({tag, " conv"}, 32'(converged), 32'(exp_conv));
    endtask

    initial begin
        // Power-on reset.
        #2;
        check("rst_valid", 32'(ind_valid), 32'd0);
        check("rst_fb_ready", 32'(fb_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gen", 32'(generation), 32'd0);
        check("rst_conv", 32'(converged), 32'd0);
        check("rst_ind", 32'(individual), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Sampling threshold around 128; cGA with winner==loser changes nothing.
        gen_samples("t2", mk(8'h7F, 8'h7F, 8'h7F, 8'h7F), mk(8'h80, 8'h80, 8'h80, 8'h80),
                    4'b1111, 4'b0000);
        feedback("t2", 1'b1, 4'b0110, 4'b0110, 5'd16, 1, 1'b0);

        // Consumer stall: individual and valid held while random moves.
        @(negedge clk);
        start = 1'b1; ind_ready = 1'b0; random = mk(8'h7F, 8'h7F, 8'h7F, 8'h7F);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            random = (k % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
            check("t3 stall_valid", 32'(ind_valid), 32'd1);
            check("t3 stall_ind", 32'(individual), 32'hF);
            @(negedge clk);
        end
        ind_ready = 1'b1; random = 32'hFFFF_FFFF;
        @(negedge clk);
        ind_ready = 1'b0;
        check("t3 second_ind", 32'(individual), 32'h0);
        check("t3 still_sample", 32'(ind_valid), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("t3 held_valid", 32'(ind_valid), 32'd1);
        check("t3 no_fb_ready", 32'(fb_ready), 32'd0);
        ind_ready = 1'b1;
        @(negedge clk);
        check("t3 wait_valid", 32'(ind_valid), 32'd0);
        check("t3 fb_ready", 32'(fb_ready), 32'd1);

        // PBIL step: winner 1010, tax 16 -> p = {144,112,144,112}.
        feedback("t4", 1'b0, 4'b1010, 4'b0000, 5'd16, 2, 1'b0);
        gen_samples("t4 probe", mk(8'd143, 8'd111, 8'd143, 8'd111),
                    mk(8'd144, 8'd112, 8'd144, 8'd112), 4'b1111, 4'b0000);

        // Reset while waiting for feedback.
        rst = 1'b0;
        #1;
        check("t1 valid", 32'(ind_valid), 32'd0);
        check("t1 fb_ready", 32'(fb_ready), 32'd0);
        check("t1 busy", 32'(busy), 32'd0);
        check("t1 gen", 32'(generation), 32'd0);
        check("t1 conv", 32'(converged), 32'd0);
        check("t1 ind", 32'(individual), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // cGA: only bit 1 differs -> p[1]=144, others 128 (also confirms reset restored 128).
        gen_samples("t5", mk(8'h7F, 8'h7F, 8'h7F, 8'h7F), mk(8'h80, 8'h80, 8'h80, 8'h80),
                    4'b1111, 4'b0000);
        feedback("t5", 1'b1, 4'b1010, 4'b1000, 5'd16, 1, 1'b0);
        gen_samples("t5 probe", mk(8'd127, 8'd127, 8'd143, 8'd127),
                    mk(8'd128, 8'd128, 8'd144, 8'd128), 4'b1111, 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Saturation: 128 + 9*15 clamps at 255, converged only after the ninth step.
        for (int g = 1; g <= 9; g++) begin
            gen_samples("t6", 32'h0, 32'h0, 4'b1111, 4'b1111);
            feedback("t6", 1'b0, 4'b1111, 4'b0000, 5'd15, g, (g == 9));
        end
        gen_samples("t6 probe", mk(8'hFE, 8'hFE, 8'hFE, 8'hFE), 32'hFFFF_FFFF,
                    4'b1111, 4'b0000);
        feedback("t6 sat", 1'b0, 4'b1111, 4'b0000, 5'd15, 10, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
